alu_seq: RTL and testbench

//  Parametrised, handshaked CHIP-8 datapath ALU; successor to the combinational 8-bit ALU.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_seq_if.sv | 37 +++
 rtl/alu_bcd_iter.sv | 64 ++++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Op codes, FSM states and small helpers for the alu_seq ALU.
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [3:0] {
    OP_OR   = 4'd0,
    OP_AND  = 4'd1,
    OP_XOR  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_SUBN = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_EQL  = 4'd8,
    OP_GRE  = 4'd9,
    OP_INC  = 4'd10,
    OP_BCD  = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic op_is_shift(input alu_op_t op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_if
// Brief  : Request/response handshake bundle between decode and alu_seq.
// Rev    : 1.0  initial release
// ============================================================================
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int W          = 8,
  parameter int BCD_DIGITS = 3
) ();

  logic                      in_valid;
  logic                      in_ready;
  alu_op_t                   op;
  logic [W-1:0]              x;
  logic [W-1:0]              y;
  logic                      out_valid;
  logic                      out_ready;
  logic [W-1:0]              res;
  logic                      flag;
  logic [4*BCD_DIGITS-1:0]   bcd;
  logic                      err;

  modport master (
    output in_valid, op, x, y, out_ready,
    input  in_ready, out_valid, res, flag, bcd, err
  );

  modport slave (
    input  in_valid, op, x, y, out_ready,
    output in_ready, out_valid, res, flag, bcd, err
  );

endinterface
`default_nettype wire

// File: rtl/alu_bcd_iter.sv
`default_nettype none
// ============================================================================
// Module : alu_bcd_iter
// Brief  : Iterative double-dabble binary-to-BCD, one bit per cycle (W cycles).
//          Instantiated by alu_seq only when ALU_BCD_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module alu_bcd_iter #(
  parameter int W          = 8,
  parameter int BCD_DIGITS = 3
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    i_start,
  input  wire logic [W-1:0]            i_bin,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [4*BCD_DIGITS-1:0]      o_bcd
);

  localparam int              c_CW   = $clog2(W + 1);
  localparam logic [c_CW-1:0] c_NBIT = W[c_CW-1:0];
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [W-1:0]             r_bin;
  logic [4*BCD_DIGITS-1:0]  r_bcd;
  logic [c_CW-1:0]          r_cnt;
  logic                     r_busy;
  logic [4*BCD_DIGITS-1:0]  w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= c_NBIT;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      // Adjust digits >=5, then shift the whole {bcd,bin} chain left by one.
      {r_bcd, r_bin} <= {w_adj[4*BCD_DIGITS-2:0], r_bin, 1'b0};
      r_cnt          <= r_cnt - c_ONE;
      if (r_cnt == c_ONE)
        r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == c_ONE);
  assign o_bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module : alu_seq
// Brief  : Handshaked CHIP-8 ALU: single-cycle logic/arith, iterative shifts,
//          VF-style flag. Define ALU_BCD_EN to enable the iterative BCD op.
// Rev    : 1.0  initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int W          = 8,
  parameter int BCD_DIGITS = 3
) (
  input  wire logic clk,
  input  wire logic rst_n,
  alu_seq_if.slave  bus
);

  localparam int              c_CW   = $clog2(W + 1);
  localparam logic [W-1:0]    c_W_OP = W[W-1:0];
  localparam logic [c_CW-1:0] c_W_K  = W[c_CW-1:0];
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  alu_state_t       r_state, w_state_nxt;
  alu_op_t          r_op;
  logic [W-1:0]     r_res;
  logic             r_flag;
  logic             r_err;
  logic [c_CW-1:0]  r_cnt;

  logic             w_accept;
  logic [c_CW-1:0]  w_k;
  logic [W:0]       w_sum;
  logic [W:0]       w_inc;
  logic [W-1:0]     w_res;
  logic             w_flag;
  logic             w_err;
  logic             w_long;
  logic             w_bcd_last;
  logic             w_busy_last;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_k      = (bus.y >= c_W_OP) ? c_W_K : bus.y[c_CW-1:0];
  assign w_sum    = {1'b0, bus.x} + {1'b0, bus.y};
  assign w_inc    = {1'b0, bus.x} + {{W{1'b0}}, 1'b1};

  // Result of a single-cycle op, or the initial shift/BCD load value.
  always_comb begin
    w_res  = '0;
    w_flag = 1'b0;
    w_err  = 1'b0;
    w_long = op_is_shift(bus.op) && (w_k != '0);
    case (bus.op)
      OP_OR:   w_res = bus.x | bus.y;
      OP_AND:  w_res = bus.x & bus.y;
      OP_XOR:  w_res = bus.x ^ bus.y;
      OP_ADD:  {w_flag, w_res} = w_sum;
      OP_SUB:  begin w_res = bus.x - bus.y; w_flag = (bus.x >= bus.y); end
      OP_SUBN: begin w_res = bus.y - bus.x; w_flag = (bus.y >= bus.x); end
      OP_INC:  {w_flag, w_res} = w_inc;
      OP_EQL:  w_res = {{(W-1){1'b0}}, (bus.x == bus.y)};
      OP_GRE:  w_res = {{(W-1){1'b0}}, (bus.x > bus.y)};
      OP_SHL, OP_SHR: w_res = bus.x;
`ifdef ALU_BCD_EN
      OP_BCD:  begin w_res = bus.x; w_long = 1'b1; end
`endif
      default: w_err = 1'b1;
    endcase
  end

`ifdef ALU_BCD_EN
  logic                      w_bcd_start;
  logic                      w_bcd_busy;
  logic                      w_bcd_done;
  logic [4*BCD_DIGITS-1:0]   w_bcd;

  assign w_bcd_start = w_accept && (bus.op == OP_BCD);

  alu_bcd_iter #(
    .W          (W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_bcd_start),
    .i_bin   (bus.x),
    .o_busy  (w_bcd_busy),
    .o_done  (w_bcd_done),
    .o_bcd   (w_bcd)
  );

  assign w_bcd_last = w_bcd_busy && w_bcd_done;
  assign bus.bcd    = ((r_state == ST_DONE) && (r_op == OP_BCD)) ? w_bcd : '0;
`else
  assign w_bcd_last = 1'b0;
  assign bus.bcd    = '0;
`endif

  assign w_busy_last = op_is_shift(r_op) ? (r_cnt == c_ONE) : w_bcd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_OR;
      r_res   <= '0;
      r_flag  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= bus.op;
        r_res  <= w_res;
        r_flag <= w_flag;
        r_err  <= w_err;
        r_cnt  <= w_k;
      end else if ((r_state == ST_BUSY) && op_is_shift(r_op)) begin
        // The flag register catches each bit as it leaves the operand.
        r_cnt <= r_cnt - c_ONE;
        if (r_op == OP_SHL)
          {r_flag, r_res} <= {r_res, 1'b0};
        else
          {r_res, r_flag} <= {1'b0, r_res};
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid)
          w_state_nxt = w_long ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (w_busy_last)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.res  = r_res;
  assign bus.flag = r_flag;
  assign bus.err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_seq
// Brief  : Directed self-checking bench for alu_seq with a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.W(W), .BCD_DIGITS(D)) bus ();

  alu_seq #(.W(W), .BCD_DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit chk_en    = 1'b0;
  bit m_pending = 1'b0;
  bit cmp_v;
  int m_acc, m_lat, m_res, m_flag, m_err, m_bcd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one operation, straight from the arithmetic rules.
  function automatic void model(input int op, input int x, input int y,
                                output int res, output int flag, output int err,
                                output int bcd, output int lat);
    int mask;
    int k;
    mask = (1 << W) - 1;
    k    = (y > W) ? W : y;
    res = 0; flag = 0; err = 0; bcd = 0; lat = 1;
    case (op)
      OP_OR:   res = x | y;
      OP_AND:  res = x & y;
      OP_XOR:  res = x ^ y;
      OP_ADD:  begin res = (x + y) & mask; flag = ((x + y) > mask) ? 1 : 0; end
      OP_SUB:  begin res = (x - y) & mask; flag = (x >= y) ? 1 : 0; end
      OP_SUBN: begin res = (y - x) & mask; flag = (y >= x) ? 1 : 0; end
      OP_INC:  begin res = (x + 1) & mask; flag = (x == mask) ? 1 : 0; end
      OP_EQL:  res = (x == y) ? 1 : 0;
      OP_GRE:  res = (x > y) ? 1 : 0;
      OP_SHL:  begin
        res  = (x << k) & mask;
        flag = (k == 0) ? 0 : ((x >> (W - k)) & 1);
        lat  = k + 1;
      end
      OP_SHR:  begin
        res  = x >> k;
        flag = (k == 0) ? 0 : ((x >> (k - 1)) & 1);
        lat  = k + 1;
      end
`ifdef ALU_BCD_EN
      OP_BCD:  begin
        res = x;
        bcd = ((x / 100) % 10) * 256 + ((x / 10) % 10) * 16 + (x % 10);
        lat = W + 1;
      end
`endif
      default: err = 1;
    endcase
  endfunction

  // Per-cycle comparison of handshake and result against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!m_pending) begin
        check("idle in_ready", bus.in_ready, 1);
        check("idle out_valid", bus.out_valid, 0);
      end else begin
        cmp_v = (cyc >= m_acc + m_lat - 1);
        check("out_valid timing", bus.out_valid, cmp_v);
        check("in_ready while busy", bus.in_ready, 0);
        if (cmp_v) begin
          check("res", bus.res, m_res);
          check("flag", bus.flag, m_flag);
          check("err", bus.err, m_err);
          check("bcd", bus.bcd, m_bcd);
        end
      end
    end
  end

  task automatic arm_model(input int op, input int x, input int y);
    model(op, x, y, m_res, m_flag, m_err, m_bcd, m_lat);
    m_acc     = cyc;
    m_pending = 1'b1;
  endtask

  task automatic run(input int op, input int x, input int y, input int hold,
                     input int eres, input int eflag, input int eerr, input int elat,
                     input int ebcd, input string tag);
    int r, f, e, b, l;
    bit seen;
    logic [3:0] opb;
    model(op, x, y, r, f, e, b, l);
    check({tag, " model res"}, r, eres);
    check({tag, " model flag"}, f, eflag);
    check({tag, " model err"}, e, eerr);
    check({tag, " model lat"}, l, elat);
    check({tag, " model bcd"}, b, ebcd);

    opb = op[3:0];
    @(posedge clk); #1;
    bus.op       = alu_op_t'(opb);
    bus.x        = x[W-1:0];
    bus.y        = y[W-1:0];
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x        = ~x[W-1:0];
    bus.y        = ~y[W-1:0];
    arm_model(op, x, y);

    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({tag, " completes"}, seen, 1);
    if (!seen) begin
      m_pending = 1'b0;
      rst_n = 1'b0; #1; rst_n = 1'b1;
      return;
    end
    check({tag, " res literal"}, bus.res, eres);

    // Backpressure: a competing request must be ignored while DONE is held.
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = OP_OR;
      bus.x        = 8'h5A;
      bus.y        = 8'hA5;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    m_pending     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = OP_OR;
    bus.x         = '0;
    bus.y         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset res", bus.res, 0);
    check("reset flag", bus.flag, 0);
    check("reset err", bus.err, 0);
    check("reset bcd", bus.bcd, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    //  op       x      y     hold res    flag err lat bcd
    run(OP_ADD,  'hF0, 'h20, 0,  'h10,  1,   0,  1,  0, "add carry");
    run(OP_OR,   'h0F, 'hF0, 0,  'hFF,  0,   0,  1,  0, "or");
    run(OP_AND,  'h3C, 'h0F, 0,  'h0C,  0,   0,  1,  0, "and");
    run(OP_XOR,  'hAA, 'h0F, 0,  'hA5,  0,   0,  1,  0, "xor");
    run(OP_SUB,  'h05, 'h07, 0,  'hFE,  0,   0,  1,  0, "sub borrow");
    run(OP_SUB,  'h07, 'h07, 0,  'h00,  1,   0,  1,  0, "sub equal");
    run(OP_SUBN, 'h05, 'h07, 0,  'h02,  1,   0,  1,  0, "subn");
    run(OP_INC,  'hFF, 'h00, 0,  'h00,  1,   0,  1,  0, "inc wrap");
    run(OP_EQL,  'h33, 'h33, 0,  'h01,  0,   0,  1,  0, "eql");
    run(OP_GRE,  'h33, 'h34, 0,  'h00,  0,   0,  1,  0, "gre false");
    run(OP_SHL,  'h81, 'h01, 0,  'h02,  1,   0,  2,  0, "shl 1");
    run(OP_SHR,  'h81, 'h09, 0,  'h00,  1,   0,  9,  0, "shr sat");
    run(OP_SHR,  'h81, 'h00, 0,  'h81,  0,   0,  1,  0, "shr zero");
    run(OP_SHL,  'h81, 'h08, 0,  'h00,  1,   0,  9,  0, "shl full");
    run(OP_SHR,  'hB4, 'h03, 0,  'h16,  1,   0,  4,  0, "shr 3");
    run(OP_ADD,  'h12, 'h34, 5,  'h46,  0,   0,  1,  0, "add backpressure");
`ifdef ALU_BCD_EN
    run(OP_BCD,  'hFE, 'h00, 0,  'hFE,  0,   0,  9,  'h254, "bcd");
`else
    run(OP_BCD,  'hFE, 'h00, 0,  'h00,  0,   1,  1,  0, "bcd off");
`endif
    run(15,      'h12, 'h34, 0,  'h00,  0,   1,  1,  0, "illegal");

    // Reset in the middle of a 6-bit shift.
    @(posedge clk); #1;
    bus.op       = OP_SHL;
    bus.x        = 8'h81;
    bus.y        = 8'h06;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    arm_model(OP_SHL, 'h81, 'h06);
    repeat (2) begin @(posedge clk); #1; end
    rst_n     = 1'b0;
    m_pending = 1'b0;
    #1;
    check("abort out_valid", bus.out_valid, 0);
    check("abort in_ready", bus.in_ready, 1);
    check("abort res", bus.res, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(OP_ADD,  'h01, 'h02, 0,  'h03,  0,   0,  1,  0, "add after reset");

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
